// File: rtl/calc_seq.sv
// Handshaked sequencer around an external 4-bit add/sub unit: registers operands,
// captures the result and flags, and keeps an accumulator, sticky overflow and op counter.
module calc_seq #(
  parameter logic [3:0] ACC_INIT = 4'h0,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  output logic [3:0]       alu_x,
  output logic [3:0]       alu_y,
  output logic             alu_sel,
  input  logic [3:0]       alu_z,
  input  logic             alu_v,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_zf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_z,
  output logic [3:0]       res_flags,
  output logic [3:0]       acc,
  output logic             sticky_v,
  input  logic             acc_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t     state, state_next;
  logic       cmd_fire, res_fire;
  logic [3:0] acc_next;
  logic       sticky_next;

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    acc_next    = acc;
    sticky_next = sticky_v;
    res_fire    = res_valid & res_ready;

    case (state)
      IDLE:    cmd_ready = rst_n;
      HOLD:    cmd_ready = res_ready;
      default: cmd_ready = 1'b0;
    endcase
    cmd_fire = cmd_valid & cmd_ready;

    case (state)
      IDLE: if (cmd_fire) state_next = EXEC;
      EXEC: state_next = HOLD;
      HOLD: if (res_fire) state_next = cmd_fire ? EXEC : IDLE;
      default: state_next = IDLE;
    endcase

    // acc_next is also what an ACC op accepted on this edge operates on
    if (res_fire) begin
      acc_next    = res_z;
      sticky_next = sticky_v | res_flags[3];
    end
    if (acc_clr) begin
      acc_next    = ACC_INIT;
      sticky_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_x     <= 4'h0;
      alu_y     <= 4'h0;
      alu_sel   <= 1'b0;
      res_valid <= 1'b0;
      res_z     <= 4'h0;
      res_flags <= 4'h0;
      acc       <= ACC_INIT;
      sticky_v  <= 1'b0;
      op_count  <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      sticky_v <= sticky_next;

      if (cmd_fire) begin
        alu_x   <= cmd_op[1] ? acc_next : cmd_a;
        alu_y   <= cmd_b;
        alu_sel <= cmd_op[0];
      end

      // A result is offered exactly once; a back-to-back op reloads it from EXEC
      if (state == EXEC) begin
        res_z     <= alu_z;
        res_flags <= {alu_v, alu_c, alu_n, alu_zf};
        res_valid <= 1'b1;
      end else if (res_fire) begin
        res_valid <= 1'b0;
      end

      if (res_fire && (op_count != {CNT_W{1'b1}})) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_seq.sv
// Scoreboard bench for calc_seq paired with a behavioural 4-bit add/sub unit.
module tb_calc_seq;

  localparam logic [3:0] ACC_INIT = 4'h0;
  localparam int         CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_ready;
  logic [1:0]       cmd_op;
  logic [3:0]       cmd_a, cmd_b;
  logic [3:0]       alu_x, alu_y, alu_z;
  logic             alu_sel, alu_v, alu_c, alu_n, alu_zf;
  logic             res_valid, res_ready;
  logic [3:0]       res_z, res_flags, acc;
  logic             sticky_v, acc_clr;
  logic [CNT_W-1:0] op_count;

  calc_seq #(.ACC_INIT(ACC_INIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
    .alu_z(alu_z), .alu_v(alu_v), .alu_c(alu_c), .alu_n(alu_n), .alu_zf(alu_zf),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_flags(res_flags),
    .acc(acc), .sticky_v(sticky_v), .acc_clr(acc_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Gate-style add/sub unit: X + (Y ^ SEL) + SEL; N is the true sign of the result
  logic [4:0] sum;
  logic [3:0] y_eff;
  always_comb begin
    y_eff  = alu_y ^ {4{alu_sel}};
    sum    = {1'b0, alu_x} + {1'b0, y_eff} + {4'b0, alu_sel};
    alu_z  = sum[3:0];
    alu_c  = sum[4];
    alu_v  = (alu_x[3] == y_eff[3]) && (sum[3] != alu_x[3]);
    alu_n  = sum[3] ^ alu_v;
    alu_zf = (sum[3:0] == 4'h0);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference arithmetic on signed/unsigned integers; returns {z, V, C, N, zero}
  function automatic logic [7:0] ref_calc(input logic sub, input logic [3:0] x, input logic [3:0] y);
    int sx, sy, r, u;
    logic [3:0] z;
    logic v, c, n, zf;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    r  = sub ? sx - sy : sx + sy;
    u  = sub ? int'(x) - int'(y) : int'(x) + int'(y);
    z  = u[3:0];
    c  = sub ? (u >= 0) : (u > 15);
    v  = (r > 7) || (r < -8);
    n  = (r < 0);
    zf = (z == 4'h0);
    return {z, v, c, n, zf};
  endfunction

  // Model state: phase 0 = waiting for a command, 1 = computing, 2 = result offered
  logic [7:0] exp_q[$];
  logic [8:0] exp_alu;
  logic [3:0] acc_m;
  logic       sticky_m;
  int         cnt_m, phase, cyc, hs_count;
  logic [3:0] hist_z[$];
  logic [3:0] hist_f[$];
  int         acc_cyc[$];

  initial begin
    acc_m = ACC_INIT; sticky_m = 1'b0; cnt_m = 0; phase = 0; cyc = 0; hs_count = 0;
    exp_alu = '0;
  end

  // Monitor: compares DUT against the model each cycle, then advances the model
  always @(negedge clk) begin
    logic hs, acc_ev, exp_cmd_ready;
    logic [7:0] e;
    logic [3:0] x;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_m = ACC_INIT; sticky_m = 1'b0; cnt_m = 0; phase = 0;
    end else begin
      exp_cmd_ready = (phase == 0) ? 1'b1 : (phase == 2) ? res_ready : 1'b0;
      check("res_valid", res_valid, (phase == 2));
      check("cmd_ready", cmd_ready, exp_cmd_ready);
      check("acc", acc, acc_m);
      check("sticky_v", sticky_v, sticky_m);
      check("op_count", op_count, cnt_m);
      if (phase == 1) check("alu_inputs", {alu_sel, alu_x, alu_y}, exp_alu);
      if (phase == 2) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("result", {res_z, res_flags}, exp_q[0]);
      end

      hs     = (phase == 2) && res_ready;
      acc_ev = exp_cmd_ready && cmd_valid;
      if (hs && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        acc_m    = e[7:4];
        sticky_m = sticky_m | e[3];
        if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
        hist_z.push_back(res_z);
        hist_f.push_back(res_flags);
        hs_count++;
      end
      if (acc_clr) begin
        acc_m = ACC_INIT; sticky_m = 1'b0;
      end
      if (phase == 1) phase = 2;
      else if (phase == 2 && hs) phase = acc_ev ? 1 : 0;
      else if (phase == 0 && acc_ev) phase = 1;
      if (acc_ev) begin
        x = cmd_op[1] ? acc_m : cmd_a;
        exp_q.push_back(ref_calc(cmd_op[0], x, cmd_b));
        exp_alu = {cmd_op[0], x, cmd_b};
        acc_cyc.push_back(cyc);
      end
    end
  end

  // Consumer side: res_ready policy and acc_clr pulses
  int   mode = 0;      // 0 always ready, 1 random, 2 stalled
  logic clr_req = 1'b0;
  initial begin
    res_ready = 1'b1;
    acc_clr   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(9) < 7);
        default: res_ready = 1'b0;
      endcase
      acc_clr = clr_req || (mode == 1 && $urandom_range(19) == 0);
      clr_req = 1'b0;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (hs_count >= target) begin
        @(posedge clk);
        #2;
        return;
      end
    end
    check("result_timeout", hs_count, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_z"}, res_z, 0);
    check({tag, "_res_flags"}, res_flags, 0);
    check({tag, "_alu_xysel"}, {alu_x, alu_y, alu_sel}, 0);
    check({tag, "_acc"}, acc, ACC_INIT);
    check({tag, "_sticky"}, sticky_v, 0);
    check({tag, "_op_count"}, op_count, 0);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 4'h0; cmd_b = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    rst_n = 1'b1;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1);

    issue(2'b00, 4'd3, 4'd4);
    wait_hs(1);
    check("ex1_z", hist_z[$], 7);
    check("ex1_flags", hist_f[$], 4'b0000);
    check("ex1_acc", acc, 7);
    check("ex1_count", op_count, 1);

    issue(2'b00, 4'd7, 4'd1);
    wait_hs(2);
    check("ex2_z", hist_z[$], 8);
    check("ex2_flags", hist_f[$], 4'b1000);
    check("ex2_sticky", sticky_v, 1);

    issue(2'b01, 4'd5, 4'd5);
    wait_hs(3);
    check("ex3_z", hist_z[$], 0);
    check("ex3_flags", hist_f[$], 4'b0101);
    check("ex3_acc", acc, 0);

    issue(2'b00, 4'd3, 4'd4);
    wait_hs(4);
    issue(2'b10, 4'd0, 4'd2);
    issue(2'b11, 4'd0, 4'd4);
    wait_hs(6);
    check("chain_first_z", hist_z[$-1], 9);
    check("chain_second_z", hist_z[$], 5);
    check("chain_accept_gap", acc_cyc[$] - acc_cyc[$-1], 2);

    mode = 2;
    issue(2'b00, 4'd1, 4'd2);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_res_z", res_z, 3);
      if (i == 1) clr_req = 1'b1;
    end
    check("clr_acc", acc, ACC_INIT);
    check("clr_sticky", sticky_v, 0);
    mode = 0;
    wait_hs(7);
    check("after_stall_acc", acc, 3);

    base = hs_count;
    issue(2'b00, 4'd6, 4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("exec_rst");
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_result_after_reset", hs_count, base);

    mode = 1;
    base = hs_count;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
      issue(2'($urandom_range(3)), 4'($urandom_range(15)), 4'($urandom_range(15)));
    end
    wait_hs(base + 300);
    mode = 0;
    check("op_count_saturated", op_count, 255);
    check("queue_drained", exp_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
